// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] pc;
    logic [WIDTH_DEF-1:0] inst;
  } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, inst} pairs; slot0 is always the head.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     din,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t slot0;
  entry_t slot1;
  logic   do_pop;
  logic   do_push;

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = slot0;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          slot1 <= '0;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Sequential instruction fetcher: walks memory from address 0, buffers two
// entries for decode, honours redirects and halts after the last word drains.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] inst,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_pc,
  output logic [WIDTH-1:0] out_inst,
  output logic [WIDTH-1:0] out_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             halted
);

  localparam int unsigned    AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_next;
  logic          push;
  logic          pop;
  logic          flush;
  logic          pop_req;
  logic          redir_in_range;
  entry_t        din;
  entry_t        head;
  logic [1:0]    count;

  assign pop_req        = (count != 2'd0) && out_ready;
  assign redir_in_range = redir_pc < WIDTH'(DEPTH);
  assign din.pc         = WIDTH_DEF'(pc_q);
  assign din.inst       = WIDTH_DEF'(inst);

  assign pc        = WIDTH'(pc_q);
  assign out_pc    = WIDTH'(head.pc);
  assign out_inst  = WIDTH'(head.inst);
  assign out_valid = (count != 2'd0);

  fetch_queue u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc_q  <= '0;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
    end
  end

  // Next state and pc; redirects outrank fetch progress while busy.
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_next = ST_FETCH;
          pc_next    = '0;
        end
      end
      ST_FETCH, ST_DRAIN: begin
        if (redir_valid) begin
          if (redir_in_range) begin
            state_next = ST_FETCH;
            pc_next    = AW'(redir_pc);
          end else begin
            state_next = ST_HALT;
          end
        end else if (state == ST_FETCH) begin
          if (push) begin
            if (pc_q == LAST) state_next = ST_DRAIN;
            else              pc_next    = pc_q + AW'(1);
          end
        end else if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
          state_next = ST_HALT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Queue controls and status outputs decoded from the current state.
  always_comb begin
    push   = 1'b0;
    pop    = 1'b0;
    flush  = 1'b0;
    busy   = 1'b0;
    halted = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        halted = (state == ST_HALT);
        flush  = start;
        pop    = pop_req && !start;
      end
      ST_FETCH, ST_DRAIN: begin
        busy = 1'b1;
        if (redir_valid) begin
          flush = 1'b1;
        end else begin
          pop  = pop_req;
          push = (state == ST_FETCH) && ((count < 2'd2) || pop_req);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_sequencer;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_DRAIN = 2;
  localparam int M_HALT  = 3;

  logic        clk = 1'b0;
  logic        rst_n, start, redir_valid, out_ready;
  logic [15:0] redir_pc, pc, inst, out_inst, out_pc;
  logic        out_valid, busy, halted;
  logic [15:0] mem [16];

  int checks = 0;
  int errors = 0;
  int m_mode = M_IDLE;
  int m_addr = 0;
  int mq[$];

  always #5 clk = ~clk;
  assign inst = mem[pc[3:0]];

  fetch_sequencer #(.DEPTH(16), .WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pc          (pc),
    .inst        (inst),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .halted      (halted)
  );

  typedef struct {
    bit          rst_n;
    bit          start;
    bit          rv;
    logic [15:0] rpc;
    bit          rdy;
    bit          e_valid;
    logic [15:0] e_opc;
    logic [15:0] e_inst;
    bit          chk_data;
    logic [15:0] e_pc;
    bit          e_busy;
    bit          e_halted;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: a list of pending addresses plus a fetch cursor.
  task automatic model_step(input bit r, input bit st, input bit rv,
                            input logic [15:0] rp, input bit rdy);
    if (!r) begin
      m_mode = M_IDLE;
      m_addr = 0;
      mq.delete();
    end else if (m_mode == M_IDLE || m_mode == M_HALT) begin
      if (st) begin
        m_mode = M_FETCH;
        m_addr = 0;
        mq.delete();
      end
    end else if (rv) begin
      mq.delete();
      if (rp < 16) begin
        m_mode = M_FETCH;
        m_addr = int'(rp);
      end else begin
        m_mode = M_HALT;
      end
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (m_mode == M_FETCH && mq.size() < 2) begin
        mq.push_back(m_addr);
        if (m_addr == 15) m_mode = M_DRAIN;
        else m_addr = m_addr + 1;
      end else if (m_mode == M_DRAIN && mq.size() == 0) begin
        m_mode = M_HALT;
      end
    end
  endtask

  task automatic model_cmp();
    chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("m_out_pc", 32'(out_pc), 32'(mq[0]));
      chk("m_out_inst", 32'(out_inst), 32'(mem[mq[0]]));
    end
    chk("m_pc", 32'(pc), 32'(m_addr));
    chk("m_busy", 32'(busy), 32'(m_mode == M_FETCH || m_mode == M_DRAIN));
    chk("m_halted", 32'(halted), 32'(m_mode == M_HALT));
  endtask

  task automatic cycle(input bit r, input bit st, input bit rv,
                       input logic [15:0] rp, input bit rdy);
    rst_n       = r;
    start       = st;
    redir_valid = rv;
    redir_pc    = rp;
    out_ready   = rdy;
    @(posedge clk);
    model_step(r, st, rv, rp, rdy);
    @(negedge clk);
    model_cmp();
  endtask

  initial begin
    int last;
    int n;
    bit r, st, rv, rdy;
    logic [15:0] rp;

    mem[0] = 16'h500A;
    mem[1] = 16'h50BC;
    for (int i = 2; i < 16; i++) mem[i] = 16'hA000 | 16'(i);

    tbl[0]  = '{0, 0, 0, 16'h0,    1, 0, 16'h0, 16'h0,    1, 16'd0,  0, 0};
    tbl[1]  = '{1, 1, 0, 16'h0,    1, 0, 16'h0, 16'h0,    0, 16'd0,  1, 0};
    tbl[2]  = '{1, 0, 0, 16'h0,    1, 1, 16'd0, 16'h500A, 1, 16'd1,  1, 0};
    tbl[3]  = '{1, 0, 0, 16'h0,    1, 1, 16'd1, 16'h50BC, 1, 16'd2,  1, 0};
    tbl[4]  = '{1, 0, 0, 16'h0,    0, 1, 16'd1, 16'h50BC, 1, 16'd3,  1, 0};
    tbl[5]  = '{1, 0, 1, 16'd9,    1, 0, 16'h0, 16'h0,    0, 16'd9,  1, 0};
    tbl[6]  = '{1, 0, 0, 16'h0,    1, 1, 16'd9, 16'hA009, 1, 16'd10, 1, 0};
    tbl[7]  = '{1, 0, 1, 16'h0020, 1, 0, 16'h0, 16'h0,    0, 16'd10, 0, 1};
    tbl[8]  = '{1, 1, 0, 16'h0,    1, 0, 16'h0, 16'h0,    0, 16'd0,  1, 0};
    tbl[9]  = '{1, 0, 0, 16'h0,    1, 1, 16'd0, 16'h500A, 1, 16'd1,  1, 0};
    tbl[10] = '{0, 0, 0, 16'h0,    1, 0, 16'h0, 16'h0,    1, 16'd0,  0, 0};

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].rst_n, tbl[i].start, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].e_pc));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].e_halted));
      if (tbl[i].chk_data) begin
        chk($sformatf("tbl%0d_out_pc", i), 32'(out_pc), 32'(tbl[i].e_opc));
        chk($sformatf("tbl%0d_out_inst", i), 32'(out_inst), 32'(tbl[i].e_inst));
      end
    end

    // Stall decode after start: queue fills, head holds, pc stops at 2.
    cycle(1, 1, 0, 16'h0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 16'h0, 0);
      if (i >= 1) chk("stall_hold_out_pc", 32'(out_pc), 32'd0);
    end
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_pc", 32'(pc), 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("release_valid", 32'(out_valid), 32'd1);
      chk("release_order", 32'(out_pc), 32'(i));
      cycle(1, 0, 0, 16'h0, 1);
    end

    // Run to the end of memory, drain, halt, then restart.
    last = -1;
    n = 0;
    while (!halted && n < 100) begin
      if (out_valid) last = int'(out_pc);
      cycle(1, 0, 0, 16'h0, 1);
      n++;
    end
    chk("end_timeout", 32'(n < 100), 32'd1);
    chk("end_last_out_pc", 32'(last), 32'd15);
    chk("end_halted", 32'(halted), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_empty", 32'(out_valid), 32'd0);
    cycle(1, 1, 0, 16'h0, 1);
    cycle(1, 0, 0, 16'h0, 1);
    chk("restart_valid", 32'(out_valid), 32'd1);
    chk("restart_out_pc", 32'(out_pc), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    for (int k = 0; k < 3000; k++) begin
      r   = ($urandom_range(0, 99) != 0);
      st  = ($urandom_range(0, 19) == 0);
      rv  = ($urandom_range(0, 24) == 0);
      rp  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15))
                                         : 16'($urandom_range(16, 40));
      rdy = ($urandom_range(0, 9) < 7);
      cycle(r, st, rv, rp, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
